// File: rtl/uart_pkg.sv
// Shared receive-FSM states and register map for uart_rx_port.
// The RxParity state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
`ifdef UART_RX_PARITY_EN
        RxParity,
`endif
        RxStop
    } RxState;

    localparam logic [2:0] UART_RX_STATUS = 3'b000;
    localparam logic [2:0] UART_RX_DATA   = 3'b001;

    localparam int STAT_AVAIL  = 0;
    localparam int STAT_OVR    = 1;
    localparam int STAT_FERR   = 2;
    localparam int STAT_IRQ_EN = 3;
    localparam int STAT_PERR   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_rx_port: pointers carry one extra wrap bit so
// full and empty are distinguishable; a pop frees a slot for a same-cycle push.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// with a small receive FIFO, sticky error flags and a level interrupt.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd_strobe,
    output logic       rd_busy,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    input  logic       rx_in,
    output logic       irq
);
    localparam int DIVISOR = CLOCK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

    RxState           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic             rd_busy_q, rd_busy_d;
    logic [2:0]       rd_addr_q, rd_addr_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             rxs, expired, rx_push, ferr_set, ovr_set, status_wr;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_head, status;
`ifdef UART_RX_PARITY_EN
    logic             perr_q, perr_d, perr_set;
    logic             unused_in;
    assign unused_in = ^{in_data[7:5], in_data[0]};
`else
    logic             unused_in;
    assign unused_in = ^{in_data[7:4], in_data[0]};
`endif

    assign rxs     = sync2_q;
    assign expired = (cnt_q == '0);

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = expired ? cnt_q : cnt_q - 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state_q)
            RxIdle: if (!rxs) begin
                cnt_d   = HALF_LOAD;
                state_d = RxStart;
            end
            RxStart: if (expired) begin
                if (rxs) begin
                    state_d = RxIdle;
                end else begin
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                    state_d   = RxData;
                end
            end
            RxData: if (expired) begin
                shift_d   = {rxs, shift_q[7:1]};
                cnt_d     = FULL_LOAD;
                bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx_q == 3'd7) state_d = RxParity;
`else
                if (bit_idx_q == 3'd7) state_d = RxStop;
`endif
            end
`ifdef UART_RX_PARITY_EN
            RxParity: if (expired) begin
                perr_set = (rxs != ^shift_q);
                cnt_d    = FULL_LOAD;
                state_d  = RxStop;
            end
`endif
            RxStop: if (expired) begin
                rx_push  = rxs;
                ferr_set = !rxs;
                state_d  = RxIdle;
            end
            default: state_d = RxIdle;
        endcase
    end

    // Register writes, then the read handshake; sticky sets override write-1-clear.
    always_comb begin
        status_wr = !cs && !wr && (addr == UART_RX_STATUS);
        ovr_set   = rx_push && fifo_full && !fifo_pop;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        irq_en_d  = irq_en_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        if (status_wr) begin
            if (in_data[STAT_OVR])  ovr_d  = 1'b0;
            if (in_data[STAT_FERR]) ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (in_data[STAT_PERR]) perr_d = 1'b0;
`endif
            irq_en_d = in_data[STAT_IRQ_EN];
        end
        if (ovr_set)  ovr_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (perr_set) perr_d = 1'b1;
`endif

        status              = 8'h00;
        status[STAT_AVAIL]  = !fifo_empty;
        status[STAT_OVR]    = ovr_q;
        status[STAT_FERR]   = ferr_q;
        status[STAT_IRQ_EN] = irq_en_q;
`ifdef UART_RX_PARITY_EN
        status[STAT_PERR]   = perr_q;
`endif

        rd_busy_d  = rd_busy_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;
        fifo_pop   = 1'b0;
        if (rd_busy_q) begin
            rd_busy_d = 1'b0;
            if (rd_addr_q == UART_RX_STATUS) begin
                out_data_d = status;
            end else if (rd_addr_q == UART_RX_DATA && !fifo_empty) begin
                out_data_d = fifo_head;
                fifo_pop   = 1'b1;
            end else begin
                out_data_d = 8'h00;
            end
        end else if (!cs && rd_strobe) begin
            rd_busy_d = 1'b1;
            rd_addr_d = addr;
        end

        irq_d = irq_en_q && !fifo_empty;
    end

    // NOTE: state is updated only with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= RxIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_addr_q  <= '0;
            out_data_q <= 8'h00;
        end else begin
            sync1_q    <= rx_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rd_busy_q  <= rd_busy_d;
            rd_addr_q  <= rd_addr_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
`endif

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (fifo_pop),
        .wdata (shift_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign rd_busy  = rd_busy_q;
    assign out_data = out_data_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at DIVISOR = 16 (CLOCK_FREQ = 16, BAUD = 1).
module tb_uart_rx_port;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b1, wr = 1'b1, rd_strobe = 1'b0, rx_in = 1'b1;
    logic [2:0] addr = 3'b000;
    logic [7:0] in_data = 8'h00;
    logic       rd_busy, irq;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] A_STATUS = 3'b000;
    localparam logic [2:0] A_DATA   = 3'b001;

    uart_rx_port #(.CLOCK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cs        (cs),
        .wr        (wr),
        .rd_strobe (rd_strobe),
        .rd_busy   (rd_busy),
        .addr      (addr),
        .in_data   (in_data),
        .out_data  (out_data),
        .rx_in     (rx_in),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d,
                            output logic busy_n, output logic busy_n1);
        cs = 1'b0; addr = a; rd_strobe = 1'b1;
        @(posedge clock); #1;
        rd_strobe = 1'b0;
        busy_n = rd_busy;
        @(posedge clock); #1;
        busy_n1 = rd_busy;
        d = out_data;
        cs = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
        @(posedge clock); #1;
        cs = 1'b1; wr = 1'b1;
    endtask

    // trace[c] holds irq as seen just after the edge that ends line cycle c.
    task automatic send_frame(input logic [7:0] b, input logic stop, output logic [159:0] trace);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 16; j++) begin
                rx_in = bits[i];
                @(posedge clock); #1;
                trace[i*16+j] = irq;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic b0, b1;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        n_checks++;
        if (irq !== 1'b0 || rd_busy !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b rd_busy=%b out_data=%h, need 0 0 00", irq, rd_busy, out_data);
        end
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL reset_status: got %h need 00", d);
        end
        n_checks++;
        if (b0 !== 1'b1 || b1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_pulse: got %b%b need 10", b0, b1);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b need 0", irq);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        send_frame(8'h4F, 1'b1, tr);
        idle(4);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h01) begin
            n_fail++; $display("FAIL single_avail: status %h need 01", d);
        end
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'h4F) begin
            n_fail++; $display("FAIL single_data: got %h need 4f", d);
        end
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL single_status_after: got %h need 00", d);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(20);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL glitch_status: got %h need 00", d);
        end
        send_frame(8'hA5, 1'b1, tr);
        idle(4);
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'hA5) begin
            n_fail++; $display("FAIL glitch_next_frame: got %h need a5", d);
        end
    endtask

    task automatic test_framing_error();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        send_frame(8'h55, 1'b0, tr);
        idle(20);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h04) begin
            n_fail++; $display("FAIL ferr_status: got %h need 04", d);
        end
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL ferr_fifo_empty: got %h need 00", d);
        end
        bus_write(A_STATUS, 8'h04);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL ferr_clear: got %h need 00", d);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, tr);
        idle(4);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h03) begin
            n_fail++; $display("FAIL ovr_status: got %h need 03", d);
        end
        for (int i = 1; i <= 5; i++) begin
            bus_read(A_DATA, d, b0, b1);
            n_checks++;
            if (d !== ((i <= 4) ? 8'(i) : 8'h00)) begin
                n_fail++;
                $display("FAIL ovr_read%0d: got %h need %h", i, d, (i <= 4) ? 8'(i) : 8'h00);
            end
        end
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h02) begin
            n_fail++; $display("FAIL ovr_sticky: got %h need 02", d);
        end
        bus_write(A_STATUS, 8'h02);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL ovr_clear: got %h need 00", d);
        end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        bus_write(A_STATUS, 8'h08);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h08) begin
            n_fail++; $display("FAIL irq_en_readback: got %h need 08", d);
        end
        send_frame(8'h4F, 1'b1, tr);
        // Stop sample lands at the edge ending cycle 154, so avail follows it
        // and irq is first seen after the edge ending cycle 155.
        n_checks++;
        if (tr[154] !== 1'b0 || tr[155] !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise: trace[154:155]=%b%b need 01", tr[154], tr[155]);
        end
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'h4F || irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_read: data %h irq %b need 4f 1", d, irq);
        end
        idle(1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_fall: got %b need 0", irq);
        end
        bus_write(A_STATUS, 8'h00);
    endtask

    task automatic test_busy_strobe();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        send_frame(8'h11, 1'b1, tr);
        send_frame(8'h22, 1'b1, tr);
        idle(4);
        cs = 1'b0; addr = A_DATA; rd_strobe = 1'b1;
        idle(2);
        rd_strobe = 1'b0;
        n_checks++;
        if (out_data !== 8'h11 || rd_busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_first: data %h busy %b need 11 0", out_data, rd_busy);
        end
        idle(3);
        cs = 1'b1;
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'h22) begin
            n_fail++; $display("FAIL busy_single_pop: got %h need 22", d);
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] d;
        logic [159:0] tr;
        logic b0, b1;
        send_frame(8'h7E, 1'b1, tr);
        rx_in = 1'b0;
        idle(40);
        reset = 1'b0; rx_in = 1'b1;
        idle(1);
        reset = 1'b1;
        idle(200);
        bus_read(A_STATUS, d, b0, b1);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL midreset_status: got %h need 00", d);
        end
        send_frame(8'h3C, 1'b1, tr);
        idle(4);
        bus_read(A_DATA, d, b0, b1);
        n_checks++;
        if (d !== 8'h3C) begin
            n_fail++; $display("FAIL midreset_next: got %h need 3c", d);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_irq();
        test_busy_strobe();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
